exu_alu_core: RTL and testbench
===============================

# exu_alu_core

Executes the operation selected by the EXU operand-select stage: consumes `alu_a`, `alu_b` and `alu_func` and produces `alu_result` for write-back, branch resolution and the LSU address path. Simple integer ops complete in one cycle. Optional multiply and divide ops run iteratively over 32 cycles. A valid/ready handshake on both sides lets the control FSM stall while the core is busy.

## Interface
Parameters:
- `WIDTH`, default `` `ISA_WIDTH `` (32): operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  operands and func are valid this cycle.
- `in_ready`  out  1  core can accept; equals (state == IDLE).
- `alu_a`  in  WIDTH  operand A.
- `alu_b`  in  WIDTH  operand B.
- `alu_func`  in  `` `ALU_FUNC_WIDTH ``  operation code.
- `out_valid`  out  1  `alu_result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `alu_result`  out  WIDTH  result, registered.
- `busy`  out  1  state is BUSY (multi-cycle op in flight).

## Operation
- Handshake: a transfer happens when `in_valid && in_ready`. Operands and func are captured on that edge and need not be held afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MUL/MULHU/DIVU/REMU.
  - BUSY → DONE when the iteration counter reaches 31.
  - DONE → IDLE when `out_ready`.
- No overlap: a new op is never accepted in DONE, even when `out_ready` is high in that cycle.
- Single-cycle ops, all mod 2^32:
  - `ADD_S` computes a+b. `SUB_S` computes a−b.
  - `EQ` and `NE` return {31'b0, cmp}.
  - `LT_S` is a signed compare. `LT_U` is an unsigned compare. Both return 0/1.
  - `AND`, `OR`, `XOR`: bitwise.
  - `SLL`, `SRL`, `SRA` shift by `b[4:0]`.
- `NO_FUNC` and any undefined code return 0 with one-cycle latency. There is no error flag.
- Multi-cycle ops (unsigned):
  - `MUL`: low 32 bits of a×b, shift-add.
  - `MULHU`: high 32 bits of a×b.
  - `DIVU` and `REMU`: restoring division, one quotient bit per cycle.
  - Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns a. The full 32 iterations still run, so latency stays fixed.
- `alu_result` holds its value through DONE and after return to IDLE, until the next result is written.

## Timing
- Reset values (all outputs, registered): state IDLE, `out_valid`=0, `alu_result`=0, `busy`=0, iteration counter 0. This gives `in_ready`=1 once `rst` deasserts.
- Single-cycle op: accepted at edge N, `out_valid`=1 from edge N+1.
- Multi-cycle op: accepted at edge N, `busy` is high for cycles N+1..N+32, and `out_valid`=1 from edge N+33.
- `out_valid` stays high until the edge at which `out_ready`=1. It drops at that edge and `in_ready` rises in the same cycle.
- Reset asserted mid-operation: on the next edge, abort and return to IDLE. The partial product or quotient is discarded and `alu_result` is cleared to 0.
- `in_valid` while not ready: ignored, no capture. The upstream stage must hold its request.
- Counter is 5 bits and wraps 31 → 0 on the BUSY → DONE transition.

## Configuration
- Macro `EXU_ALU_MULDIV_EN`.
- Defined: the multi-cycle ops are implemented and `exu_alu_muldiv` is instantiated.
- Undefined:
  - MUL, MULHU, DIVU and REMU behave as undefined codes: result 0, one-cycle latency.
  - BUSY is unreachable and `busy` is tied to 0.
  - No muldiv logic is synthesized.

## Structure
- `config.v` (shared header) holds the new `ALU_FUNC` codes: `NE`, `LT_S`, `LT_U`, `AND`, `OR`, `XOR`, `SLL`, `SRL`, `SRA`, `MUL`, `MULHU`, `DIVU`, `REMU`.
  - Existing codes `NO_FUNC`, `ADD_S`, `SUB_S` and `EQ` keep their values.
  - `ALU_FUNC_WIDTH` widens only if the new codes need it.
- FSM state encodings are local to this module.
- One sub-module, `exu_alu_muldiv`:
  - Owns the iterative datapath and the counter.
  - Interface: start, op, a, b, done, result.
  - The top module keeps the FSM, the single-cycle datapath and the result register.

## Test plan
- Reset, then ADD_S a=0xFFFFFFFF, b=1 → `out_valid` at edge N+1, result 0x00000000. Reset values are checked first.
- SUB_S 3−5 → 0xFFFFFFFE. LT_S a=0xFFFFFFFF, b=1 → 1. LT_U with the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0x10000×0x10000 → 0 and MULHU → 1. `busy` is high for exactly 32 cycles and `out_valid` rises at N+33.
- DIVU 100/7 → 14 and REMU → 2. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with 33-cycle latency.
- Back-pressure: hold `out_ready`=0 for 10 cycles with `in_valid`=1 → result stable, `in_ready`=0 and no second capture. Accept occurs only after the DONE → IDLE transition.
- Assert `rst`=0 at cycle 10 of a DIVU → next edge has IDLE, `out_valid`=0, `alu_result`=0. Build without `EXU_ALU_MULDIV_EN` → MUL returns 0 in 1 cycle.

Source files
------------

// File: rtl/exu_alu_core_pkg.sv
// exu_alu_core_pkg: ALU function codes, operand width and muldiv op helpers
// shared by the EXU ALU core and its iterative multiply/divide unit.
package exu_alu_core_pkg;

    localparam int ISA_WIDTH      = 32;
    localparam int ALU_FUNC_WIDTH = 5;

    typedef logic [ALU_FUNC_WIDTH-1:0] alu_func_t;

    localparam alu_func_t ALU_NO_FUNC = 5'd0;
    localparam alu_func_t ALU_ADD_S   = 5'd1;
    localparam alu_func_t ALU_SUB_S   = 5'd2;
    localparam alu_func_t ALU_EQ      = 5'd3;
    localparam alu_func_t ALU_NE      = 5'd4;
    localparam alu_func_t ALU_LT_S    = 5'd5;
    localparam alu_func_t ALU_LT_U    = 5'd6;
    localparam alu_func_t ALU_AND     = 5'd7;
    localparam alu_func_t ALU_OR      = 5'd8;
    localparam alu_func_t ALU_XOR     = 5'd9;
    localparam alu_func_t ALU_SLL     = 5'd10;
    localparam alu_func_t ALU_SRL     = 5'd11;
    localparam alu_func_t ALU_SRA     = 5'd12;
    localparam alu_func_t ALU_MUL     = 5'd13;
    localparam alu_func_t ALU_MULHU   = 5'd14;
    localparam alu_func_t ALU_DIVU    = 5'd15;
    localparam alu_func_t ALU_REMU    = 5'd16;

    // Bit 1 selects divide, bit 0 selects the upper half of the datapath.
    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_e;

    function automatic logic is_muldiv(input alu_func_t f);
        return (f == ALU_MUL) || (f == ALU_MULHU) ||
               (f == ALU_DIVU) || (f == ALU_REMU);
    endfunction

    function automatic md_op_e md_op(input alu_func_t f);
        md_op_e op;
        case (f)
            ALU_MULHU: op = MD_MULHU;
            ALU_DIVU:  op = MD_DIVU;
            ALU_REMU:  op = MD_REMU;
            default:   op = MD_MUL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exu_alu_muldiv.sv
// exu_alu_muldiv: 32-iteration shift-add multiplier / restoring divider.
// Compiled only when EXU_ALU_MULDIV_EN is defined.
`ifdef EXU_ALU_MULDIV_EN
module exu_alu_muldiv
    import exu_alu_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] result_o
);

    logic        run_q, run_d;
    logic [4:0]  cnt_q, cnt_d;
    md_op_e      op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;

    logic [32:0] mul_sum;
    logic [64:0] shl;
    logic [32:0] rem_s;
    logic [31:0] diff;
    logic        ge;
    logic        is_div;
    logic [63:0] step;

    assign is_div = (op_q == MD_DIVU) || (op_q == MD_REMU);

    // acc holds {hi, lo} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        shl     = {acc_q, 1'b0};
        rem_s   = shl[64:32];
        ge      = rem_s >= {1'b0, opnd_q};
        diff    = rem_s[31:0] - opnd_q;
        if (is_div) begin
            step = ge ? {diff, shl[31:1], 1'b1} : shl[63:0];
        end else begin
            step = {mul_sum, acc_q[31:1]};
        end
    end

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        opnd_d = opnd_q;
        acc_d  = acc_q;
        if (start_i) begin
            run_d  = 1'b1;
            cnt_d  = 5'd0;
            op_d   = md_op_e'(op_i);
            opnd_d = op_i[1] ? b_i : a_i;
            acc_d  = {32'd0, op_i[1] ? a_i : b_i};
        end else if (run_q) begin
            acc_d = step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_d = 1'b0;
            end
        end
    end

    // Result is taken from the final step so the top latches it on done.
    assign done_o   = run_q && (cnt_q == 5'd31);
    assign result_o = ((op_q == MD_MULHU) || (op_q == MD_REMU)) ?
                      step[63:32] : step[31:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q  <= 1'b0;
            cnt_q  <= 5'd0;
            op_q   <= MD_MUL;
            opnd_q <= 32'd0;
            acc_q  <= 64'd0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            opnd_q <= opnd_d;
            acc_q  <= acc_d;
        end
    end

endmodule
`endif

// File: rtl/exu_alu_core.sv
// exu_alu_core: EXU ALU with valid/ready handshake and registered result.
// Define EXU_ALU_MULDIV_EN to add iterative MUL/MULHU/DIVU/REMU.
module exu_alu_core
    import exu_alu_core_pkg::*;
#(
    parameter int WIDTH = ISA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          alu_a,
    input  logic [WIDTH-1:0]          alu_b,
    input  logic [ALU_FUNC_WIDTH-1:0] alu_func,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          alu_result,
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] sc_result;
    logic             accept;
    logic             go_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign accept = in_valid && in_ready;

    always_comb begin
        sc_result = '0;
        case (alu_func)
            ALU_ADD_S: sc_result = alu_a + alu_b;
            ALU_SUB_S: sc_result = alu_a - alu_b;
            ALU_EQ:    sc_result = {{(WIDTH-1){1'b0}}, alu_a == alu_b};
            ALU_NE:    sc_result = {{(WIDTH-1){1'b0}}, alu_a != alu_b};
            ALU_LT_S:  sc_result = {{(WIDTH-1){1'b0}},
                                    $signed(alu_a) < $signed(alu_b)};
            ALU_LT_U:  sc_result = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            ALU_AND:   sc_result = alu_a & alu_b;
            ALU_OR:    sc_result = alu_a | alu_b;
            ALU_XOR:   sc_result = alu_a ^ alu_b;
            ALU_SLL:   sc_result = alu_a << alu_b[4:0];
            ALU_SRL:   sc_result = alu_a >> alu_b[4:0];
            ALU_SRA:   sc_result = $signed(alu_a) >>> alu_b[4:0];
            default:   sc_result = '0;
        endcase
    end

`ifdef EXU_ALU_MULDIV_EN
    assign go_busy = accept && is_muldiv(alu_func);
    assign busy    = (state_q == ST_BUSY);

    exu_alu_muldiv u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (go_busy),
        .op_i     (md_op(alu_func)),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .done_o   (md_done),
        .result_o (md_result)
    );
`else
    // Without muldiv the four codes fall through to the undefined-code path.
    assign go_busy   = 1'b0;
    assign busy      = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (go_busy) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_result;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_result;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign alu_result = result_q;

endmodule

// File: tb/tb_exu_alu_core.sv
// tb_exu_alu_core: directed vectors for exu_alu_core, both build variants.
// Muldiv cases are compiled in when EXU_ALU_MULDIV_EN is defined.
module tb_exu_alu_core;
    import exu_alu_core_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_func;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        busy;

    int vectors;
    int miscompares;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t sc_tab [16];

    exu_alu_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from IDLE; return edges-to-valid, busy samples, result.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int nb, output logic [31:0] res);
        @(negedge clk);
        alu_func = f;
        alu_a    = a;
        alu_b    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        nb  = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nb++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (busy) nb++;
        res = alu_result;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_func  = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (alu_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset result got %h want 0", alu_result);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy got %b want 0", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        int          lat;
        int          nb;
        logic [31:0] res;
        sc_tab = '{
            '{ALU_ADD_S,   32'hFFFFFFFF, 32'h00000001, 32'h00000000},
            '{ALU_SUB_S,   32'h00000003, 32'h00000005, 32'hFFFFFFFE},
            '{ALU_LT_S,    32'hFFFFFFFF, 32'h00000001, 32'h00000001},
            '{ALU_LT_U,    32'hFFFFFFFF, 32'h00000001, 32'h00000000},
            '{ALU_SRA,     32'h80000000, 32'h00000004, 32'hF8000000},
            '{ALU_EQ,      32'h00000005, 32'h00000005, 32'h00000001},
            '{ALU_NE,      32'h00000005, 32'h00000005, 32'h00000000},
            '{ALU_NE,      32'h00000005, 32'h00000006, 32'h00000001},
            '{ALU_AND,     32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
            '{ALU_OR,      32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0},
            '{ALU_XOR,     32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
            '{ALU_SLL,     32'h00000001, 32'h00000023, 32'h00000008},
            '{ALU_SRL,     32'h80000000, 32'h00000004, 32'h08000000},
            '{ALU_LT_S,    32'h00000001, 32'hFFFFFFFF, 32'h00000000},
            '{ALU_NO_FUNC, 32'h00000001, 32'h00000002, 32'h00000000},
            '{5'h1F,       32'h00000001, 32'h00000002, 32'h00000000}
        };
        for (int i = 0; i < 16; i++) begin
            run_op(sc_tab[i].f, sc_tab[i].a, sc_tab[i].b, lat, nb, res);
            vectors++;
            if (res !== sc_tab[i].y) begin
                miscompares++;
                $display("FAIL single[%0d] result got %h want %h",
                         i, res, sc_tab[i].y);
            end
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL single[%0d] latency got %0d want 1", i, lat);
            end
            consume();
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL single[%0d] release got v=%b r=%b want v=0 r=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

`ifdef EXU_ALU_MULDIV_EN
    task automatic test_muldiv();
        int          lat;
        int          nb;
        logic [31:0] res;
        vec_t        md_tab [8];
        md_tab = '{
            '{ALU_MUL,   32'h00010000, 32'h00010000, 32'h00000000},
            '{ALU_MULHU, 32'h00010000, 32'h00010000, 32'h00000001},
            '{ALU_MUL,   32'h00000007, 32'h00000006, 32'h0000002A},
            '{ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
            '{ALU_DIVU,  32'd100,      32'd7,        32'd14},
            '{ALU_REMU,  32'd100,      32'd7,        32'd2},
            '{ALU_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF},
            '{ALU_REMU,  32'd5,        32'd0,        32'd5}
        };
        for (int i = 0; i < 8; i++) begin
            run_op(md_tab[i].f, md_tab[i].a, md_tab[i].b, lat, nb, res);
            vectors++;
            if (res !== md_tab[i].y) begin
                miscompares++;
                $display("FAIL muldiv[%0d] result got %h want %h",
                         i, res, md_tab[i].y);
            end
            vectors++;
            if (lat !== 33) begin
                miscompares++;
                $display("FAIL muldiv[%0d] latency got %0d want 33", i, lat);
            end
            vectors++;
            if (nb !== 32) begin
                miscompares++;
                $display("FAIL muldiv[%0d] busy cycles got %0d want 32", i, nb);
            end
            consume();
        end
    endtask
`else
    task automatic test_no_muldiv();
        int          lat;
        int          nb;
        logic [31:0] res;
        run_op(ALU_ADD_S, 32'd2, 32'd3, lat, nb, res);
        consume();
        run_op(ALU_MUL, 32'd7, 32'd6, lat, nb, res);
        vectors++;
        if (res !== 32'h0 || lat !== 1 || nb !== 0) begin
            miscompares++;
            $display("FAIL nomuldiv MUL got res=%h lat=%0d busy=%0d want 0/1/0",
                     res, lat, nb);
        end
        consume();
        run_op(ALU_DIVU, 32'd100, 32'd7, lat, nb, res);
        vectors++;
        if (res !== 32'h0 || lat !== 1 || nb !== 0) begin
            miscompares++;
            $display("FAIL nomuldiv DIVU got res=%h lat=%0d busy=%0d want 0/1/0",
                     res, lat, nb);
        end
        consume();
    endtask
`endif

    task automatic test_backpressure();
        int          lat;
        int          nb;
        logic [31:0] res;
        run_op(ALU_ADD_S, 32'd2, 32'd3, lat, nb, res);
        @(negedge clk);
        alu_func = ALU_SUB_S;
        alu_a    = 32'd10;
        alu_b    = 32'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (alu_result !== 32'd5 || in_ready !== 1'b0 ||
                out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall[%0d] got res=%h r=%b v=%b want 5/0/1",
                         i, alu_result, in_ready, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_result !== 32'd5) begin
            miscompares++;
            $display("FAIL no_overlap got v=%b r=%b res=%h want 0/1/5",
                     out_valid, in_ready, alu_result);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || alu_result !== 32'd9) begin
            miscompares++;
            $display("FAIL held_req got v=%b res=%h want 1/9",
                     out_valid, alu_result);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        int          lat;
        int          nb;
        logic [31:0] res;
`ifdef EXU_ALU_MULDIV_EN
        @(negedge clk);
        alu_func = ALU_DIVU;
        alu_a    = 32'd100;
        alu_b    = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        repeat (9) @(posedge clk);
`else
        run_op(ALU_ADD_S, 32'd4, 32'd4, lat, nb, res);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            alu_result !== 32'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort got r=%b v=%b res=%h busy=%b want 1/0/0/0",
                     in_ready, out_valid, alu_result, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        run_op(ALU_ADD_S, 32'd1, 32'd1, lat, nb, res);
        vectors++;
        if (res !== 32'd2 || lat !== 1) begin
            miscompares++;
            $display("FAIL recover got res=%h lat=%0d want 2/1", res, lat);
        end
        consume();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
`ifdef EXU_ALU_MULDIV_EN
        test_muldiv();
`else
        test_no_muldiv();
`endif
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
